rx_packet_ctrl: RTL and testbench

RX_PACKET_CTRL -- requirements
Module: rx_packet_ctrl

---
 rtl/rx_packet_ctrl.sv | 148 ++++++++++++++
 tb/tb_rx_packet_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_ctrl.sv
// Receive-side packet controller: checks the sync byte, forwards payload bytes
// to a downstream FIFO, and reports clean completion or a sticky error.
module rx_packet_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic       fifo_full,
  output logic       rcving,
  output logic       w_enable,
  output logic [7:0] w_data,
  output logic       r_error,
  output logic       pkt_done,
  output logic [6:0] byte_cnt
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE, SYNC_WAIT, RCV, STORE, DONE, ERR_WAIT, ERR_IDLE
  } state_t;

  state_t     state_q;
  logic       rcving_q;
  logic       w_enable_q;
  logic [7:0] w_data_q;
  logic       r_error_q;
  logic       pkt_done_q;
  logic [6:0] byte_cnt_q;
  logic       eop_latch_q;

  // eop only counts when it coincides with a bit-period strobe
  logic eop_s;
  assign eop_s = eop & shift_enable;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      rcving_q    <= 1'b0;
      w_enable_q  <= 1'b0;
      w_data_q    <= 8'h00;
      r_error_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      byte_cnt_q  <= 7'd0;
      eop_latch_q <= 1'b0;
    end else begin
      w_enable_q <= 1'b0;
      pkt_done_q <= 1'b0;
      case (state_q)
        IDLE, ERR_IDLE: begin
          if (d_edge) begin
            state_q     <= SYNC_WAIT;
            byte_cnt_q  <= 7'd0;
            r_error_q   <= 1'b0;
            rcving_q    <= 1'b1;
            eop_latch_q <= 1'b0;
          end
        end
        SYNC_WAIT: begin
          if (byte_received) begin
            if (rcv_data == SYNC_BYTE) begin
              // a sync byte arriving with eop is an empty but valid packet
              if (eop_s) begin
                state_q    <= DONE;
                pkt_done_q <= 1'b1;
                rcving_q   <= 1'b0;
              end else begin
                state_q <= RCV;
              end
            end else begin
              r_error_q <= 1'b1;
              if (eop_s) begin
                state_q  <= ERR_IDLE;
                rcving_q <= 1'b0;
              end else begin
                state_q <= ERR_WAIT;
              end
            end
          end else if (eop_s) begin
            state_q   <= ERR_IDLE;
            r_error_q <= 1'b1;
            rcving_q  <= 1'b0;
          end
        end
        RCV: begin
          if (byte_received) begin
            if (!fifo_full && (byte_cnt_q < MAX_CNT)) begin
              state_q     <= STORE;
              w_data_q    <= rcv_data;
              w_enable_q  <= 1'b1;
              byte_cnt_q  <= byte_cnt_q + 7'd1;
              eop_latch_q <= eop_s;
            end else begin
              r_error_q <= 1'b1;
              if (eop_s) begin
                state_q  <= ERR_IDLE;
                rcving_q <= 1'b0;
              end else begin
                state_q <= ERR_WAIT;
              end
            end
          end else if (eop_s) begin
            state_q    <= DONE;
            pkt_done_q <= 1'b1;
            rcving_q   <= 1'b0;
          end
        end
        STORE: begin
          eop_latch_q <= 1'b0;
          if (eop_latch_q || eop_s) begin
            state_q    <= DONE;
            pkt_done_q <= 1'b1;
            rcving_q   <= 1'b0;
          end else begin
            state_q <= RCV;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        ERR_WAIT: begin
          if (eop_s) begin
            state_q  <= ERR_IDLE;
            rcving_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          rcving_q <= 1'b0;
        end
      endcase
    end
  end

  assign rcving   = rcving_q;
  assign w_enable = w_enable_q;
  assign w_data   = w_data_q;
  assign r_error  = r_error_q;
  assign pkt_done = pkt_done_q;
  assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Cycle-table bench for rx_packet_ctrl: each row is one clock of stimulus plus
// the outputs expected after that edge; written bytes are checked via a queue.
module tb_rx_packet_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       n_rst2 = 1'b0;
  logic       d_edge = 1'b0;
  logic       eop = 1'b0;
  logic       shift_enable = 1'b0;
  logic       byte_received = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       fifo_full = 1'b0;

  logic       rcving1, w_enable1, r_error1, pkt_done1;
  logic [7:0] w_data1;
  logic [6:0] byte_cnt1;
  logic       rcving2, w_enable2, r_error2, pkt_done2;
  logic [7:0] w_data2;
  logic [6:0] byte_cnt2;

  always #5 clk = ~clk;

  rx_packet_ctrl dut1 (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
    .shift_enable(shift_enable), .byte_received(byte_received),
    .rcv_data(rcv_data), .fifo_full(fifo_full),
    .rcving(rcving1), .w_enable(w_enable1), .w_data(w_data1),
    .r_error(r_error1), .pkt_done(pkt_done1), .byte_cnt(byte_cnt1)
  );

  rx_packet_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(2)) dut2 (
    .clk(clk), .n_rst(n_rst2), .d_edge(d_edge), .eop(eop),
    .shift_enable(shift_enable), .byte_received(byte_received),
    .rcv_data(rcv_data), .fifo_full(fifo_full),
    .rcving(rcving2), .w_enable(w_enable2), .w_data(w_data2),
    .r_error(r_error2), .pkt_done(pkt_done2), .byte_cnt(byte_cnt2)
  );

  typedef struct packed {
    logic       de, eo, se, br;
    logic [7:0] data;
    logic       ff, push;
    logic       rcv, we;
    logic [7:0] wd;
    logic       err, done;
    logic [6:0] cnt;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb_q[$];
  vec_t tbl[$];
  vec_t tbl2[$];
  vec_t tbl3[$];

  function automatic vec_t mk(input logic de, eo, se, br, input logic [7:0] data,
                              input logic ff, push, rcv, we, input logic [7:0] wd,
                              input logic err, done, input logic [6:0] cnt);
    vec_t v;
    v.de = de; v.eo = eo; v.se = se; v.br = br; v.data = data; v.ff = ff;
    v.push = push; v.rcv = rcv; v.we = we; v.wd = wd; v.err = err;
    v.done = done; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit sel, input logic rcv, we,
                            input logic [7:0] wd, input logic err, done,
                            input logic [6:0] cnt);
    logic       a_rcv, a_we, a_err, a_done;
    logic [7:0] a_wd;
    logic [6:0] a_cnt;
    logic [7:0] exp_b;
    if (sel) begin
      a_rcv = rcving2; a_we = w_enable2; a_wd = w_data2;
      a_err = r_error2; a_done = pkt_done2; a_cnt = byte_cnt2;
    end else begin
      a_rcv = rcving1; a_we = w_enable1; a_wd = w_data1;
      a_err = r_error1; a_done = pkt_done1; a_cnt = byte_cnt1;
    end
    chk({tag, ".rcving"},   {7'd0, a_rcv},  {7'd0, rcv});
    chk({tag, ".w_enable"}, {7'd0, a_we},   {7'd0, we});
    chk({tag, ".w_data"},   a_wd,           wd);
    chk({tag, ".r_error"},  {7'd0, a_err},  {7'd0, err});
    chk({tag, ".pkt_done"}, {7'd0, a_done}, {7'd0, done});
    chk({tag, ".byte_cnt"}, {1'b0, a_cnt},  {1'b0, cnt});
    if (a_we) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s.sb: got write %0h expected no write", tag, a_wd);
      end else begin
        exp_b = sb_q.pop_front();
        chk({tag, ".sb_data"}, a_wd, exp_b);
      end
    end
  endtask

  task automatic run_row(input vec_t v, input bit sel, input string tag);
    d_edge        = v.de;
    eop           = v.eo;
    shift_enable  = v.se;
    byte_received = v.br;
    rcv_data      = v.data;
    fifo_full     = v.ff;
    if (v.push) sb_q.push_back(v.data);
    @(posedge clk);
    #1;
    check_outs(tag, sel, v.rcv, v.we, v.wd, v.err, v.done, v.cnt);
  endtask

  initial begin
    // Good packet: sync, A5, 3C, eop (eop without strobe is ignored)
    tbl.push_back(mk(1,0,0,0,8'h00,0,0, 1,0,8'h00,0,0,7'd0));
    tbl.push_back(mk(0,0,0,1,8'h80,0,0, 1,0,8'h00,0,0,7'd0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 1,0,8'h00,0,0,7'd0));
    tbl.push_back(mk(0,0,0,1,8'hA5,0,1, 1,1,8'hA5,0,0,7'd1));
    tbl.push_back(mk(0,0,0,0,8'h00,0,0, 1,0,8'hA5,0,0,7'd1));
    tbl.push_back(mk(0,0,0,1,8'h3C,0,1, 1,1,8'h3C,0,0,7'd2));
    tbl.push_back(mk(0,0,0,0,8'h00,0,0, 1,0,8'h3C,0,0,7'd2));
    tbl.push_back(mk(0,1,1,0,8'h00,0,0, 0,0,8'h3C,0,1,7'd2));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 0,0,8'h3C,0,0,7'd2));
    // Bad sync byte, later bytes ignored, error sticky until next d_edge
    tbl.push_back(mk(1,0,0,0,8'h00,0,0, 1,0,8'h3C,0,0,7'd0));
    tbl.push_back(mk(0,0,0,1,8'h81,0,0, 1,0,8'h3C,1,0,7'd0));
    tbl.push_back(mk(0,0,0,1,8'h22,0,0, 1,0,8'h3C,1,0,7'd0));
    tbl.push_back(mk(0,1,1,0,8'h00,0,0, 0,0,8'h3C,1,0,7'd0));
    tbl.push_back(mk(0,0,0,0,8'h00,0,0, 0,0,8'h3C,1,0,7'd0));
    tbl.push_back(mk(1,0,0,0,8'h00,0,0, 1,0,8'h3C,0,0,7'd0));
    // FIFO full on first data byte
    tbl.push_back(mk(0,0,0,1,8'h80,0,0, 1,0,8'h3C,0,0,7'd0));
    tbl.push_back(mk(0,0,0,1,8'h11,1,0, 1,0,8'h3C,1,0,7'd0));
    tbl.push_back(mk(0,0,0,0,8'h00,0,0, 1,0,8'h3C,1,0,7'd0));
    tbl.push_back(mk(0,1,1,0,8'h00,0,0, 0,0,8'h3C,1,0,7'd0));
    // Byte coincident with eop is stored, then pkt_done; d_edge in DONE ignored
    tbl.push_back(mk(1,0,0,0,8'h00,0,0, 1,0,8'h3C,0,0,7'd0));
    tbl.push_back(mk(0,0,0,1,8'h80,0,0, 1,0,8'h3C,0,0,7'd0));
    tbl.push_back(mk(0,1,1,1,8'h5A,0,1, 1,1,8'h5A,0,0,7'd1));
    tbl.push_back(mk(0,0,0,0,8'h00,0,0, 0,0,8'h5A,0,1,7'd1));
    tbl.push_back(mk(1,0,0,0,8'h00,0,0, 0,0,8'h5A,0,0,7'd1));
    tbl.push_back(mk(0,0,0,0,8'h00,0,0, 0,0,8'h5A,0,0,7'd1));
    // eop before any byte
    tbl.push_back(mk(1,0,0,0,8'h00,0,0, 1,0,8'h5A,0,0,7'd0));
    tbl.push_back(mk(0,1,1,0,8'h00,0,0, 0,0,8'h5A,1,0,7'd0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0, 0,0,8'h5A,1,0,7'd0));

    // MAX_BYTES=2 instance: third data byte overflows
    tbl2.push_back(mk(1,0,0,0,8'h00,0,0, 1,0,8'h00,0,0,7'd0));
    tbl2.push_back(mk(0,0,0,1,8'h80,0,0, 1,0,8'h00,0,0,7'd0));
    tbl2.push_back(mk(0,0,0,1,8'h01,0,1, 1,1,8'h01,0,0,7'd1));
    tbl2.push_back(mk(0,0,0,0,8'h00,0,0, 1,0,8'h01,0,0,7'd1));
    tbl2.push_back(mk(0,0,0,1,8'h02,0,1, 1,1,8'h02,0,0,7'd2));
    tbl2.push_back(mk(0,0,0,0,8'h00,0,0, 1,0,8'h02,0,0,7'd2));
    tbl2.push_back(mk(0,0,0,1,8'h03,0,0, 1,0,8'h02,1,0,7'd2));
    tbl2.push_back(mk(0,1,1,0,8'h00,0,0, 0,0,8'h02,1,0,7'd2));

    // After a mid-packet reset, bytes without a fresh d_edge do nothing
    tbl3.push_back(mk(0,0,0,1,8'h77,0,0, 0,0,8'h00,0,0,7'd0));
    tbl3.push_back(mk(0,0,0,0,8'h00,0,0, 0,0,8'h00,0,0,7'd0));
    tbl3.push_back(mk(0,1,1,1,8'h66,0,0, 0,0,8'h00,0,0,7'd0));

    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 0, 0, 8'h00, 0, 0, 7'd0);
    n_rst = 1'b1;

    foreach (tbl[i]) run_row(tbl[i], 1'b0, $sformatf("row%0d", i));

    // Mid-packet asynchronous reset between sync and first data byte
    run_row(mk(1,0,0,0,8'h00,0,0, 1,0,8'h5A,0,0,7'd0), 1'b0, "rst_de");
    run_row(mk(0,0,0,1,8'h80,0,0, 1,0,8'h5A,0,0,7'd0), 1'b0, "rst_sync");
    byte_received = 1'b0;
    #3;
    n_rst = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 0, 0, 8'h00, 0, 0, 7'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    foreach (tbl3[i]) run_row(tbl3[i], 1'b0, $sformatf("postrst%0d", i));

    n_rst = 1'b0;
    n_rst2 = 1'b1;
    foreach (tbl2[i]) run_row(tbl2[i], 1'b1, $sformatf("max2_row%0d", i));

    chk("sb_empty", 8'(sb_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
